// File: rtl/fb_pkg.sv
// Frame-buffer definitions shared by the write and read side controllers.
package fb_pkg;

  localparam int unsigned BANK_IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_WRITE = 2'd2
  } fb_state_e;

  typedef logic [BANK_IDX_W-1:0] bank_t;

  // Next write bank: step past the reader's bank; with two banks this lands back on cur.
  function automatic bank_t next_bank(input bank_t cur, input bank_t rd,
                                      input int unsigned num_banks);
    int unsigned n;
    n = 32'(cur) + 32'd1;
    if (n >= num_banks) n = 32'd0;
    if (n == 32'(rd)) begin
      n = n + 32'd1;
      if (n >= num_banks) n = 32'd0;
    end
    return BANK_IDX_W'(n);
  endfunction

endpackage

// File: rtl/vs_edge_det.sv
// Registers raw VS and turns its edges into start/end-of-frame strobes for either polarity.
module vs_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_vs,
  input  logic negtive_sync,
  output logic sof_c,
  output logic eof_c
);

  logic vs_q;
  logic vs_d;
  logic rise_c;
  logic fall_c;

  always_comb begin
    vs_d = i_vs;
  end

  always_ff @(posedge clk) begin
    if (rst) vs_q <= 1'b0;
    else     vs_q <= vs_d;
  end

  assign rise_c = ~vs_q & i_vs;
  assign fall_c = vs_q & ~i_vs;

  // Active-high VS: the frame starts when the pulse ends and ends when the next one begins.
  assign sof_c = negtive_sync ? rise_c : fall_c;
  assign eof_c = negtive_sync ? fall_c : rise_c;

endmodule

// File: rtl/frame_wr_ctrl.sv
// Frame buffer write controller: gates on stable timing, writes pixels into a rotating
// bank and commits the bank only when a complete, correctly sized frame has landed.
module frame_wr_ctrl
  import fb_pkg::*;
#(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned BANK_DEPTH = 2097152,
  parameter int unsigned NUM_BANKS  = 3,
  parameter int unsigned BANK_W     = BANK_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vs,
  input  logic              i_de,
  input  logic [DATA_W-1:0] i_data,
  input  logic              frame_stable,
  input  logic              negtive_sync,
  input  logic [23:0]       frame_len,
  input  logic [BANK_W-1:0] rd_bank,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done_valid,
  output logic [BANK_W-1:0] done_bank,
  output logic              err_short,
  output logic              err_long,
  output logic              busy
);

  localparam int unsigned LEN_W = 24;

  fb_state_e         state_q, state_d;
  logic [BANK_W-1:0] cur_bank_q, cur_bank_d;
  logic [LEN_W-1:0]  pix_idx_q, pix_idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              long_seen_q, long_seen_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              done_valid_q, done_valid_d;
  logic [BANK_W-1:0] done_bank_q, done_bank_d;
  logic              err_short_q, err_short_d;
  logic              err_long_q, err_long_d;
  logic              busy_q, busy_d;

  logic              sof_c;
  logic              eof_c;
  logic              len_ok_c;
  logic              pix_room_c;
  logic [ADDR_W-1:0] bank_base_c;

  vs_edge_det u_vs_edge_det (
    .clk          (clk),
    .rst          (rst),
    .i_vs         (i_vs),
    .negtive_sync (negtive_sync),
    .sof_c        (sof_c),
    .eof_c        (eof_c)
  );

  assign len_ok_c    = (frame_len != '0) && (32'(frame_len) <= BANK_DEPTH);
  assign pix_room_c  = pix_idx_q < len_q;
  assign bank_base_c = ADDR_W'(cur_bank_q) * ADDR_W'(BANK_DEPTH);

  // Next-state and registered output logic.
  always_comb begin
    state_d      = state_q;
    cur_bank_d   = cur_bank_q;
    pix_idx_d    = pix_idx_q;
    len_d        = len_q;
    long_seen_d  = long_seen_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_valid_d = 1'b0;
    done_bank_d  = done_bank_q;
    err_short_d  = 1'b0;
    err_long_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_stable) state_d = ST_ARM;
      end

      ST_ARM: begin
        if (!frame_stable) begin
          state_d = ST_IDLE;
        end else if (sof_c && len_ok_c) begin
          state_d     = ST_WRITE;
          len_d       = frame_len;
          long_seen_d = 1'b0;
          pix_idx_d   = '0;
          // A pixel coincident with SOF is the first pixel of the frame.
          if (i_de) begin
            wr_en_d   = 1'b1;
            wr_addr_d = bank_base_c;
            wr_data_d = i_data;
            pix_idx_d = LEN_W'(1);
          end
        end
      end

      ST_WRITE: begin
        if (!frame_stable) begin
          state_d = ST_IDLE;
        end else if (eof_c || sof_c) begin
          // An unexpected SOF closes the frame as short; the new frame is not captured.
          state_d = ST_ARM;
          if (eof_c && (pix_idx_q == len_q)) begin
            done_valid_d = 1'b1;
            done_bank_d  = cur_bank_q;
            cur_bank_d   = BANK_W'(next_bank(BANK_IDX_W'(cur_bank_q),
                                             BANK_IDX_W'(rd_bank), NUM_BANKS));
          end else begin
            err_short_d = 1'b1;
          end
        end else if (i_de) begin
          if (pix_room_c) begin
            wr_en_d   = 1'b1;
            wr_addr_d = bank_base_c + ADDR_W'(pix_idx_q);
            wr_data_d = i_data;
            pix_idx_d = pix_idx_q + LEN_W'(1);
          end else if (!long_seen_q) begin
            err_long_d  = 1'b1;
            long_seen_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_bank_q   <= '0;
      pix_idx_q    <= '0;
      len_q        <= '0;
      long_seen_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      done_valid_q <= 1'b0;
      done_bank_q  <= '0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_bank_q   <= cur_bank_d;
      pix_idx_q    <= pix_idx_d;
      len_q        <= len_d;
      long_seen_q  <= long_seen_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_valid_q <= done_valid_d;
      done_bank_q  <= done_bank_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
      busy_q       <= busy_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign done_valid = done_valid_q;
  assign done_bank  = done_bank_q;
  assign err_short  = err_short_q;
  assign err_long   = err_long_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_frame_wr_ctrl.sv
// Scoreboard bench for frame_wr_ctrl: a three-bank instance is fully checked, a two-bank
// instance shares the stimulus and is checked on its committed banks.
module tb_frame_wr_ctrl;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DEPTH  = 2097152;
  localparam int unsigned BW     = 2;

  localparam logic [2:0] EV_DONE  = 3'b100;
  localparam logic [2:0] EV_SHORT = 3'b010;
  localparam logic [2:0] EV_LONG  = 3'b001;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } wr_exp_t;

  typedef struct {
    logic [2:0]    kind;
    logic [BW-1:0] bank;
    int            cyc;
  } evt_exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_vs;
  logic              i_de;
  logic [DATA_W-1:0] i_data;
  logic              frame_stable;
  logic              negtive_sync;
  logic [23:0]       frame_len;
  logic [BW-1:0]     rd_bank;

  logic              wr_en, done_valid, err_short, err_long, busy;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BW-1:0]     done_bank;

  logic              d2_wr_en, d2_done_valid, d2_err_short, d2_err_long, d2_busy;
  logic [ADDR_W-1:0] d2_wr_addr;
  logic [DATA_W-1:0] d2_wr_data;
  logic [BW-1:0]     d2_done_bank;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_bank  = 0;
  int exp_bank2 = 0;

  wr_exp_t       wr_q[$];
  evt_exp_t      evt_q[$];
  logic [BW-1:0] done2_q[$];

  frame_wr_ctrl dut (
    .clk(clk), .rst(rst), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
    .frame_stable(frame_stable), .negtive_sync(negtive_sync), .frame_len(frame_len),
    .rd_bank(rd_bank), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .done_valid(done_valid), .done_bank(done_bank), .err_short(err_short),
    .err_long(err_long), .busy(busy)
  );

  frame_wr_ctrl #(.NUM_BANKS(2)) dut2 (
    .clk(clk), .rst(rst), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
    .frame_stable(frame_stable), .negtive_sync(negtive_sync), .frame_len(frame_len),
    .rd_bank(rd_bank), .wr_en(d2_wr_en), .wr_addr(d2_wr_addr), .wr_data(d2_wr_data),
    .done_valid(d2_done_valid), .done_bank(d2_done_bank), .err_short(d2_err_short),
    .err_long(d2_err_long), .busy(d2_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Candidate search: first bank after cur that the reader does not hold, else cur.
  function automatic int model_next_bank(input int cur, input int rd, input int num);
    for (int k = 1; k < num; k++) begin
      if (((cur + k) % num) != rd) return (cur + k) % num;
    end
    return cur;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string pfx);
    check_eq({pfx, "_wr_en"},      64'(wr_en),      64'(0));
    check_eq({pfx, "_wr_addr"},    64'(wr_addr),    64'(0));
    check_eq({pfx, "_wr_data"},    64'(wr_data),    64'(0));
    check_eq({pfx, "_done_valid"}, 64'(done_valid), 64'(0));
    check_eq({pfx, "_done_bank"},  64'(done_bank),  64'(0));
    check_eq({pfx, "_err_short"},  64'(err_short),  64'(0));
    check_eq({pfx, "_err_long"},   64'(err_long),   64'(0));
    check_eq({pfx, "_busy"},       64'(busy),       64'(0));
  endtask

  task automatic push_evt(input logic [2:0] kind, input int bank);
    evt_exp_t e;
    e.kind = kind;
    e.bank = BW'(bank);
    e.cyc  = cyc + 1;
    evt_q.push_back(e);
  endtask

  task automatic push_pix(input int k, input int len, input logic [DATA_W-1:0] d);
    wr_exp_t w;
    if (k < len) begin
      w.addr = ADDR_W'(exp_bank * int'(DEPTH) + k);
      w.data = d;
      w.cyc  = cyc + 1;
      wr_q.push_back(w);
    end else if (k == len) begin
      push_evt(EV_LONG, 0);
    end
  endtask

  // One frame: lead-in, SOF, lines of active pixels, EOF. abort_at/rst_at drop stable or
  // pulse reset just before that pixel index (-1 = never).
  task automatic run_frame(input int lines, input int per_line, input int len,
                           input bit sof_de, input int abort_at, input int rst_at);
    int k;
    bit live;
    bit aborted;
    logic act;
    logic [DATA_W-1:0] d;
    k = 0;
    live = 1'b1;
    aborted = 1'b0;
    act = ~negtive_sync;
    frame_len = 24'(len);
    repeat (2) begin
      i_vs = act;
      i_de = 1'b0;
      step();
    end
    d = DATA_W'($urandom);
    i_vs = ~act;
    i_de = sof_de;
    i_data = d;
    if (sof_de) begin
      push_pix(k, len, d);
      k++;
    end
    step();
    check_eq("busy_after_sof", 64'(busy), 64'(1));
    frame_len = 24'($urandom_range(1, 40));
    for (int l = 0; l < lines; l++) begin
      i_de = 1'b0;
      repeat (2) step();
      for (int p = 0; p < per_line; p++) begin
        if (live && k == rst_at) begin
          rst = 1'b1;
          i_de = 1'b0;
          step();
          check_reset("rst_mid");
          rst = 1'b0;
          live = 1'b0;
          exp_bank = 0;
          exp_bank2 = 0;
        end
        if (live && k == abort_at) begin
          frame_stable = 1'b0;
          live = 1'b0;
          aborted = 1'b1;
        end
        d = DATA_W'($urandom);
        i_de = 1'b1;
        i_data = d;
        if (live) push_pix(k, len, d);
        k++;
        step();
        if (aborted && k == abort_at + 1) check_eq("busy_after_abort", 64'(busy), 64'(0));
      end
    end
    i_de = 1'b0;
    repeat (2) step();
    i_vs = act;
    i_de = 1'b1;
    i_data = DATA_W'($urandom);
    if (live) begin
      if (k >= len) begin
        push_evt(EV_DONE, exp_bank);
        done2_q.push_back(BW'(exp_bank2));
        exp_bank  = model_next_bank(exp_bank, int'(rd_bank), 3);
        exp_bank2 = model_next_bank(exp_bank2, int'(rd_bank), 2);
      end else begin
        push_evt(EV_SHORT, 0);
      end
    end
    step();
    i_de = 1'b0;
    repeat (3) step();
    check_eq("writes_drained", 64'(wr_q.size()), 64'(0));
    check_eq("events_drained", 64'(evt_q.size()), 64'(0));
    check_eq("d2_done_drained", 64'(done2_q.size()), 64'(0));
    wr_q.delete();
    evt_q.delete();
    done2_q.delete();
    if (aborted) frame_stable = 1'b1;
  endtask

  // Output monitor: every write and pulse must match the head of its queue.
  always @(negedge clk) begin
    wr_exp_t w;
    evt_exp_t e;
    logic [BW-1:0] b2;
    if (wr_en === 1'b1) begin
      if (wr_q.size() == 0) begin
        check_eq("wr_unexpected", 64'(wr_en), 64'(0));
      end else begin
        w = wr_q.pop_front();
        check_eq("wr_addr", 64'(wr_addr), 64'(w.addr));
        check_eq("wr_data", 64'(wr_data), 64'(w.data));
        check_eq("wr_latency", 64'(cyc), 64'(w.cyc));
      end
    end
    if ((done_valid | err_short | err_long) === 1'b1) begin
      if (evt_q.size() == 0) begin
        check_eq("evt_unexpected", 64'({done_valid, err_short, err_long}), 64'(0));
      end else begin
        e = evt_q.pop_front();
        check_eq("evt_kind", 64'({done_valid, err_short, err_long}), 64'(e.kind));
        check_eq("evt_latency", 64'(cyc), 64'(e.cyc));
        if (e.kind == EV_DONE) check_eq("done_bank", 64'(done_bank), 64'(e.bank));
      end
    end
    if (d2_done_valid === 1'b1) begin
      if (done2_q.size() == 0) begin
        check_eq("d2_done_unexpected", 64'(d2_done_valid), 64'(0));
      end else begin
        b2 = done2_q.pop_front();
        check_eq("d2_done_bank", 64'(d2_done_bank), 64'(b2));
      end
    end
  end

  initial begin
    rst = 1'b1;
    i_vs = 1'b1;
    i_de = 1'b0;
    i_data = '0;
    frame_stable = 1'b0;
    negtive_sync = 1'b0;
    frame_len = 24'd16;
    rd_bank = 2'd2;
    repeat (3) step();
    check_reset("por");
    rst = 1'b0;
    step();
    frame_stable = 1'b1;
    repeat (3) step();

    // Basic frames, reader on bank 2: banks 0 then 1.
    run_frame(4, 4, 16, 1'b0, -1, -1);
    run_frame(4, 4, 16, 1'b0, -1, -1);

    // Reader on bank 1: rotation skips it; first frame has a pixel on the SOF cycle.
    rd_bank = 2'd1;
    run_frame(3, 5, 16, 1'b1, -1, -1);
    run_frame(4, 4, 16, 1'b0, -1, -1);
    run_frame(4, 4, 16, 1'b0, -1, -1);

    // Short frame, then a good one rewrites the same bank.
    run_frame(3, 4, 16, 1'b0, -1, -1);
    run_frame(4, 4, 16, 1'b0, -1, -1);

    // Long frame: 20 pixels for 16 slots.
    run_frame(5, 4, 16, 1'b0, -1, -1);

    // Stability lost after pixel 7, then a clean frame on the same bank.
    run_frame(4, 4, 16, 1'b0, 8, -1);
    run_frame(4, 4, 16, 1'b0, -1, -1);

    // Active-low VS.
    frame_stable = 1'b0;
    step();
    negtive_sync = 1'b1;
    i_vs = 1'b0;
    repeat (2) step();
    frame_stable = 1'b1;
    rd_bank = 2'd2;
    step();
    run_frame(4, 4, 16, 1'b0, -1, -1);
    rd_bank = 2'd0;
    run_frame(4, 4, 16, 1'b0, -1, -1);

    // Reset mid-frame, then writing restarts from bank 0.
    run_frame(4, 4, 16, 1'b0, -1, 5);
    run_frame(4, 4, 16, 1'b0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_wr_ctrl.md
Name: frame_wr_ctrl

Overview:
- Downstream consumer of frame_info_det: takes the raw video stream plus frame_stable, negtive_sync and the measured frame length (frame_cnt_o).
- Generates the pixel write stream into a multi-bank frame buffer.
- Gates writing until the input timing is stable and only commits a bank when a complete, correctly sized frame has landed.
- Rotates write banks and never selects the bank the reader currently holds.

Parameters:
- DATA_W, 24, pixel width in bits.
- ADDR_W, 23, frame buffer word address width.
- BANK_DEPTH, 2097152, words per bank; bank base = bank*BANK_DEPTH.
- NUM_BANKS, 3, number of buffer banks (2 or 3).
- BANK_W, 2, width of bank indices.

Ports:
- clk, in, 1, single system/pixel clock.
- rst, in, 1, synchronous active-high reset.
- i_vs, in, 1, vertical sync, raw polarity.
- i_de, in, 1, data enable, active high.
- i_data, in, DATA_W, pixel data qualified by i_de.
- frame_stable, in, 1, from frame_info_det.
- negtive_sync, in, 1, VS polarity from frame_info_det: 0 = VS active high, 1 = VS active low.
- frame_len, in, 24, expected pixels per frame (frame_cnt_o).
- rd_bank, in, BANK_W, bank currently owned by the reader.
- wr_en, out, 1, write strobe.
- wr_addr, out, ADDR_W, write address.
- wr_data, out, DATA_W, write data.
- done_valid, out, 1, one-cycle pulse: a bank was committed.
- done_bank, out, BANK_W, last committed bank (held).
- err_short, out, 1, one-cycle pulse: frame ended early.
- err_long, out, 1, one-cycle pulse: excess pixels dropped (at most once per frame).
- busy, out, 1, high while in WRITE state.

Behaviour:
- Reset values: all outputs 0; internal cur_bank=0; pix_idx=0; state IDLE.
- Edge detect: vs_q is i_vs registered.
  - negtive_sync=0: SOF is vs_q=1 and i_vs=0; EOF is vs_q=0 and i_vs=1.
  - negtive_sync=1: SOF and EOF are swapped.
- States:
  - IDLE: leave for ARM when frame_stable=1.
  - ARM: go to WRITE on SOF when frame_len!=0 and frame_len<=BANK_DEPTH; pix_idx cleared to 0. Return to IDLE when frame_stable=0.
  - WRITE:
    - Each cycle with i_de=1 and pix_idx<frame_len: next cycle wr_en=1, wr_addr=cur_bank*BANK_DEPTH+pix_idx, wr_data=i_data; then pix_idx+1. Latency is exactly 1 cycle, registered.
    - i_de=1 with pix_idx==frame_len: no write; err_long pulses once per frame.
    - On EOF with pix_idx==frame_len: done_valid=1 and done_bank=cur_bank next cycle; cur_bank advances to next_bank; go to ARM.
    - On EOF with pix_idx<frame_len: err_short pulse, no commit, cur_bank unchanged; go to ARM.
    - frame_stable=0 at any cycle: abort to IDLE, no commit, no error pulse, cur_bank unchanged.
- next_bank: n=(cur+1) mod NUM_BANKS; if n==rd_bank then n=(n+1) mod NUM_BANKS; if that equals cur (NUM_BANKS=2 case) stay on cur (overwrite).
- Simultaneous events:
  - i_de on the SOF cycle is written as pixel 0.
  - i_de on the EOF cycle is ignored.
  - Abort has priority over EOF.
  - An SOF seen while in WRITE is treated as EOF-without-commit, i.e. err_short, and the block re-arms; the new frame is not captured.
- frame_len is sampled at SOF and held for the whole frame.
- Reset mid-frame: all state cleared next cycle; no pulses are generated.
- busy = (state==WRITE).

Decomposition:
- Shared package fb_pkg holds:
  - the state encoding (IDLE/ARM/WRITE);
  - the bank index width;
  - a next_bank function (cur, rd, num_banks).
- One sub-module, vs_edge_det: registers i_vs and produces sof/eof from negtive_sync. It is reusable by the read side.

Test Plan:
- negtive_sync=0, stable=1, frame_len=16, 4 lines×4 de, rd_bank=2 → 16 writes at addr 0..15 with data matching i_data, each 1 cycle after de; done_valid with done_bank=0; next frame written at base 2097152.
- Three consecutive good frames, rd_bank=1 → banks used 0, 2, 0 (bank 1 skipped); NUM_BANKS=2 with rd_bank=1 → bank 0 reused every frame.
- frame_len=16 but only 12 de pixels → err_short pulse, no done_valid, next frame rewrites the same bank from addr 0.
- 20 de pixels with frame_len=16 → 16 writes, exactly one err_long pulse, commit on EOF.
- frame_stable falls after pixel 7 → wr_en stops next cycle, no done/err, state IDLE; writing resumes only after stable=1 and a fresh SOF.
- negtive_sync=1 with inverted VS → identical write/commit sequence to scenario 1; rst asserted mid-frame → all outputs 0 next cycle, bank back to 0.
